reg_serializer: RTL and testbench

Parallel-to-serial transmitter for 8-bit register values. It accepts a word over a valid/ready load handshake, then shifts it out one bit per accepted beat on a serial valid/ready link. It sits between a parallel-load register and a serial sink such as a debug or readback link. It is the output-side counterpart of the existing parallel-load register.

---
 rtl/reg_serializer_pkg.sv | 20 ++
 rtl/reg_serializer_if.sv | 27 ++
 rtl/reg_serializer_bit_counter.sv | 39 +++
 rtl/reg_serializer.sv | 109 ++++++++++
 tb/tb_reg_serializer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_serializer_pkg.sv
// Shared types and constants for the reg_serializer block.
// FSM state encoding, default word width, bit-counter width helper.
// No logic; imported by the interface, counter and top.
package reg_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must be able to represent 0..WIDTH.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/reg_serializer_if.sv
// Load and serial handshake bundle for reg_serializer.
// master = producer/sink side, slave = serializer side.
// Pure wiring, no latency.
interface reg_serializer_if
  import reg_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_ready;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_data, ser_ready,
    input  load_ready, ser_out, ser_valid, busy, done
  );

  modport slave (
    input  load_valid, load_data, ser_ready,
    output load_ready, ser_out, ser_valid, busy, done
  );
endinterface

// File: rtl/reg_serializer_bit_counter.sv
// Beat counter for the serializer: clears on load, counts accepted beats.
// Terminal flag is combinational from the count (0 cycles).
// Saturates at WIDTH-1, so it never wraps.
module ser_bit_counter
  import reg_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic incr_i,
  output logic term_o
);
  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] count_q, count_d;

  assign term_o = (count_q == CW'(WIDTH - 1));

  // Next count: clear has priority; hold once the last beat index is reached.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (incr_i && !term_o) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/reg_serializer.sv
// Parallel-to-serial transmitter: loads a WIDTH-bit word, shifts it out one bit per beat.
// First bit valid 1 cycle after load accept; done pulses after the last beat (WIDTH+1 cycles, +1 with parity).
// ser_ready low stalls the current bit; load_ready is high only in IDLE. Optional parity beat: REG_SERIALIZER_PARITY_EN.
module reg_serializer
  import reg_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  reg_serializer_if.slave   bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             cnt_clr, cnt_inc, cnt_term;
`ifdef REG_SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  ser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear_i (cnt_clr),
    .incr_i  (cnt_inc),
    .term_o  (cnt_term)
  );

  // Next-state, datapath next values and all handshake outputs.
  always_comb begin
    state_d        = state_q;
    shreg_d        = shreg_q;
    cnt_clr        = 1'b0;
    cnt_inc        = 1'b0;
    bus.load_ready = 1'b0;
    bus.ser_valid  = 1'b0;
    bus.ser_out    = 1'b0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;
`ifdef REG_SERIALIZER_PARITY_EN
    par_d          = par_q;
`endif
    case (state_q)
      IDLE: begin
        bus.load_ready = 1'b1;
        if (bus.load_valid) begin
          shreg_d = bus.load_data;
          cnt_clr = 1'b1;
          state_d = SHIFT;
`ifdef REG_SERIALIZER_PARITY_EN
          par_d   = ^bus.load_data;
`endif
        end
      end
      SHIFT: begin
        bus.ser_valid = 1'b1;
        bus.busy      = 1'b1;
        bus.ser_out   = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
        if (bus.ser_ready) begin
          shreg_d = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]}
                              : {shreg_q[WIDTH-2:0], 1'b0};
          cnt_inc = 1'b1;
          if (cnt_term) begin
`ifdef REG_SERIALIZER_PARITY_EN
            state_d = PARITY;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef REG_SERIALIZER_PARITY_EN
      PARITY: begin
        bus.ser_valid = 1'b1;
        bus.busy      = 1'b1;
        bus.ser_out   = par_q;
        if (bus.ser_ready) begin
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any word in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
`ifdef REG_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
`ifdef REG_SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
endmodule

// File: tb/tb_reg_serializer.sv
// Directed bench for reg_serializer: MSB-first and LSB-first instances.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// Parity scenarios are included when REG_SERIALIZER_PARITY_EN is defined.
module tb_reg_serializer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  reg_serializer_if #(.WIDTH(8)) m0 ();
  reg_serializer_if #(.WIDTH(8)) m1 ();

  reg_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(m0)
  );
  reg_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(m1)
  );

  always #5 clk = ~clk;

`ifdef REG_SERIALIZER_PARITY_EN
  localparam int BEATS = 9;
`else
  localparam int BEATS = 8;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word on m0 for exactly one accept edge, then scramble load_data.
  task automatic load0(input logic [7:0] d);
    m0.load_valid = 1'b1;
    m0.load_data  = d;
    tick();
    m0.load_valid = 1'b0;
    m0.load_data  = ~d;
  endtask

  // Full transfer on m0 with ser_ready high; exp holds the word, par its even parity.
  task automatic send_check0(input logic [7:0] d, input logic par, input string nm);
    m0.ser_ready = 1'b1;
    load0(d);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (m0.ser_valid !== 1'b1 || m0.ser_out !== d[7-i]) begin
        errors++;
        $display("FAIL %s bit%0d: got valid=%b out=%b, want valid=1 out=%b", nm, i, m0.ser_valid, m0.ser_out, d[7-i]);
      end
      tick();
    end
`ifdef REG_SERIALIZER_PARITY_EN
    checks++;
    if (m0.ser_valid !== 1'b1 || m0.ser_out !== par) begin
      errors++;
      $display("FAIL %s parity: got valid=%b out=%b, want valid=1 out=%b", nm, m0.ser_valid, m0.ser_out, par);
    end
    tick();
`endif
    checks++;
    if (m0.done !== 1'b1 || m0.ser_valid !== 1'b0 || m0.load_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s done: got done=%b valid=%b ldrdy=%b, want 1 0 0 (par=%b)", nm, m0.done, m0.ser_valid, m0.load_ready, par);
    end
    tick();
    checks++;
    if (m0.load_ready !== 1'b1 || m0.done !== 1'b0 || m0.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: got ldrdy=%b done=%b busy=%b, want 1 0 0", nm, m0.load_ready, m0.done, m0.busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (m0.load_ready !== 1'b1 || m0.ser_valid !== 1'b0 || m0.ser_out !== 1'b0 ||
        m0.busy !== 1'b0 || m0.done !== 1'b0) begin
      errors++;
      $display("FAIL reset: got rdy=%b vld=%b out=%b busy=%b done=%b, want 1 0 0 0 0",
               m0.load_ready, m0.ser_valid, m0.ser_out, m0.busy, m0.done);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_msb_a5();
    send_check0(8'hA5, 1'b0, "msb_a5");
  endtask

  task automatic test_lsb_01();
    logic [7:0] d;
    d = 8'h01;
    m1.ser_ready  = 1'b1;
    m1.load_valid = 1'b1;
    m1.load_data  = d;
    tick();
    m1.load_valid = 1'b0;
    m1.load_data  = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (m1.ser_valid !== 1'b1 || m1.ser_out !== d[i]) begin
        errors++;
        $display("FAIL lsb_01 bit%0d: got valid=%b out=%b, want valid=1 out=%b", i, m1.ser_valid, m1.ser_out, d[i]);
      end
      tick();
    end
`ifdef REG_SERIALIZER_PARITY_EN
    checks++;
    if (m1.ser_out !== 1'b1) begin
      errors++;
      $display("FAIL lsb_01 parity: got %b, want 1", m1.ser_out);
    end
    tick();
`endif
    checks++;
    if (m1.done !== 1'b1) begin
      errors++;
      $display("FAIL lsb_01 done: got %b, want 1", m1.done);
    end
    tick();
  endtask

  // Runs m0 until done, capturing accepted data bits; optional stall and mid-word load.
  task automatic collect0(input logic [7:0] d, input bit do_stall, input bit do_poke, input string nm);
    logic [7:0] got;
    int beats, cyc;
    bit seen_done;
    got = '0; beats = 0; cyc = 0; seen_done = 0;
    m0.ser_ready = 1'b1;
    load0(d);
    while (!seen_done && cyc < 40) begin
      if (do_stall && beats == 2 && cyc == 2) begin
        m0.ser_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          checks++;
          if (m0.ser_valid !== 1'b1 || m0.ser_out !== 1'b1) begin
            errors++;
            $display("FAIL %s stall%0d: got valid=%b out=%b, want 1 1", nm, s, m0.ser_valid, m0.ser_out);
          end
        end
        m0.ser_ready = 1'b1;
      end
      if (do_poke && cyc == 3) begin
        checks++;
        if (m0.load_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s busy_ldrdy: got %b, want 0", nm, m0.load_ready);
        end
        m0.load_valid = 1'b1;
        m0.load_data  = 8'h3C;
      end
      if (m0.done === 1'b1) seen_done = 1;
      if (m0.ser_valid === 1'b1 && m0.ser_ready === 1'b1) begin
        if (beats < 8) got = {got[6:0], m0.ser_out};
        beats++;
      end
      tick();
      m0.load_valid = 1'b0;
      cyc++;
    end
    checks++;
    if (!seen_done || got !== d || beats != BEATS) begin
      errors++;
      $display("FAIL %s word: got data=%h beats=%0d done=%0d, want data=%h beats=%0d done=1",
               nm, got, beats, seen_done, d, BEATS);
    end
    // Back in IDLE; the ignored request must not have been queued.
    tick();
    checks++;
    if (m0.ser_valid !== 1'b0 || m0.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s after: got valid=%b ldrdy=%b, want 0 1", nm, m0.ser_valid, m0.load_ready);
    end
  endtask

  task automatic test_stall();
    collect0(8'hF0, 1'b1, 1'b0, "stall_f0");
  endtask

  task automatic test_ignore_load();
    collect0(8'h96, 1'b0, 1'b1, "ignore_3c");
  endtask

  task automatic test_reset_mid();
    m0.ser_ready = 1'b1;
    load0(8'h5A);
    for (int i = 0; i < 4; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (m0.load_ready !== 1'b1 || m0.ser_valid !== 1'b0 || m0.ser_out !== 1'b0 ||
        m0.busy !== 1'b0 || m0.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got rdy=%b vld=%b out=%b busy=%b done=%b, want 1 0 0 0 0",
               m0.load_ready, m0.ser_valid, m0.ser_out, m0.busy, m0.done);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (m0.done !== 1'b0 || m0.busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold%0d: got done=%b busy=%b, want 0 0", i, m0.done, m0.busy);
      end
    end
    reset = 1'b0;
    tick();
    send_check0(8'h81, 1'b0, "after_rst_81");
  endtask

`ifdef REG_SERIALIZER_PARITY_EN
  task automatic test_parity();
    send_check0(8'h07, 1'b1, "par_07");
    send_check0(8'h03, 1'b0, "par_03");
  endtask
`endif

  initial begin
    m0.load_valid = 1'b0; m0.load_data = '0; m0.ser_ready = 1'b0;
    m1.load_valid = 1'b0; m1.load_data = '0; m1.ser_ready = 1'b0;
    test_reset();
    test_msb_a5();
    test_lsb_01();
    test_stall();
    test_ignore_load();
    test_reset_mid();
`ifdef REG_SERIALIZER_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
